sha256_job_scheduler: RTL
=========================

# sha256_job_scheduler

Shares one `simplified_sha256` core between `NUM_REQ` requesters. Each requester submits a job as a message address and an output address. The scheduler arbitrates round-robin and issues the job to the core with a one-cycle `start`. It then tracks the core's `done` level through busy and back to idle, reports completion to the owning requester, and aborts a hung core with a watchdog that pulses the core's reset.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..16.
- `TIMEOUT`, default 2048: watchdog limit in cycles, range 4..65535. Counts from the start pulse until `done` returns high.
- `GW`, derived as $clog2(NUM_REQ): width of the grant index.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `req_valid`, in, NUM_REQ: job request, one bit per requester.
- `req_msg_addr`, in, NUM_REQ*16: message address; requester i uses bits [16i+15:16i].
- `req_out_addr`, in, NUM_REQ*16: output address, same packing as `req_msg_addr`.
- `req_ready`, out, NUM_REQ: one-cycle pulse; the job is accepted.
- `cmp_valid`, out, NUM_REQ: one-cycle completion pulse to the owning requester.
- `cmp_error`, out, 1: qualifies `cmp_valid`; 1 means the job was aborted by the watchdog.
- `core_start`, out, 1: start pulse to the core.
- `core_message_addr`, out, 16: latched message address of the job.
- `core_output_addr`, out, 16: latched output address of the job.
- `core_done`, in, 1: the core's level-done signal, high whenever the core is idle.
- `core_reset_n`, out, 1: active-low reset to the core.
- `busy`, out, 1: high in every state except IDLE.
- `grant_id`, out, GW: index of the current or most recent grant.

## Operation
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, COMPLETE, RECOVER1, RECOVER2.
- All outputs are decoded from registered state and registered data; there are no combinational input-to-output paths.
- IDLE:
  - Arbitration runs only when some `req_valid` is high and `core_done`=1.
  - The winner is the first set bit searching upward from (`last_grant`+1) mod NUM_REQ, wrapping around.
  - On the clock edge the scheduler latches the winner's addresses into `core_*_addr`, sets `grant_id` and `last_grant` to the winner, and moves to START.
- START: `core_start`=1 and `req_ready[grant_id]`=1 for exactly this one cycle. Clear the watchdog counter and go to WAIT_BUSY.
- WAIT_BUSY: wait for `core_done`=0, then go to WAIT_DONE.
- WAIT_DONE: wait for `core_done`=1, then go to COMPLETE.
- COMPLETE: `cmp_valid[grant_id]`=1 and `cmp_error`=0 for one cycle, then return to IDLE.
- Watchdog:
  - The counter increments every cycle in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT-1 and the exit condition is not met, go to RECOVER1.
  - If `core_done` satisfies the exit condition in that same cycle, the normal transition wins.
- RECOVER1 and RECOVER2: `core_reset_n`=0 in both. In RECOVER2 also drive `cmp_valid[grant_id]`=1 and `cmp_error`=1. Then return to IDLE.
- Requester rules:
  - A requester holds `req_valid` and both addresses stable until it sees `req_ready`.
  - Deasserting `req_valid` before the grant withdraws the request; this is legal.
  - `req_valid` is ignored outside IDLE.
  - A requester may re-request in the cycle after `cmp_valid`.
- `core_message_addr` and `core_output_addr` hold their value from grant until the next grant.

## Timing
- Reset values:
  - `state`=IDLE, `last_grant`=NUM_REQ-1 (so requester 0 wins first), `grant_id`=0.
  - `req_ready`, `cmp_valid`, `cmp_error`, `core_start`, `busy`: all 0.
  - `core_*_addr`=0.
  - `core_reset_n`=0 while `reset` is high; it is deasserted on the first edge after `reset` falls.
- Reset mid-job: all outputs return to reset values immediately. No completion is reported, and the job is lost.
- Latency:
  - Request seen in IDLE at edge N: START (`req_ready`, `core_start`) is during cycle N+1.
  - Core drops `done` at edge M and raises it at edge P: `cmp_valid` is during cycle P+1.
- Minimum spacing between successive `core_start` pulses: 5 cycles.
- Watchdog: the abort completion arrives TIMEOUT+2 cycles after START.
- `core_done`=0 while in IDLE (core held or recovering) blocks granting.

## Test plan
1. Single job: req_valid=4'b0100 with addresses 0x0010/0x0100; core model goes busy for 300 cycles. Require START 1 cycle after the request, exactly one `core_start`, addresses 0x0010/0x0100 on the core, and `cmp_valid`=4'b0100 with `cmp_error`=0 one cycle after `done` rises.
2. Fairness: req_valid=4'b1111 held continuously. Require grant order 0,1,2,3,0 and exactly one `req_ready` pulse per grant.
3. Wrap and skip: `last_grant`=3, req_valid=4'b1010. Require grant 1 next, then 3.
4. Watchdog: TIMEOUT=16, core never raises `done`. Require `core_reset_n` low for 2 cycles and `cmp_valid` with `cmp_error`=1 at START+18, then the next request is granted normally.
5. Boundary: `done` rises in the same cycle the counter hits TIMEOUT-1. Require a normal completion with `cmp_error`=0.
6. Reset mid-job: assert `reset` during WAIT_DONE. Require all outputs at reset values in the same cycle, no `cmp_valid`, and requester 0 granted first afterwards.

Source files
------------

// File: rtl/sha256_job_scheduler.sv
// ---------------------------------------------------------------------------
// sha256_job_scheduler
//
// Shares one simplified_sha256 core between NUM_REQ requesters. Each
// requester submits a message address and an output address. A round-robin
// arbiter picks one job while the core is idle and issues it with a
// one-cycle start pulse. The scheduler then follows the core's level-done
// signal through busy and back to idle and reports completion to the owner.
// A watchdog aborts a hung core by pulsing its reset for two cycles and
// reports an error completion.
//
// Ports
//   clk                in   clock, rising edge
//   reset              in   asynchronous, active-high reset
//   req_valid          in   [NUM_REQ]      job request, one bit per requester
//   req_msg_addr       in   [NUM_REQ*16]   message address, requester i at [16i+15:16i]
//   req_out_addr       in   [NUM_REQ*16]   output address, same packing
//   req_ready          out  [NUM_REQ]      one-cycle accept pulse to the winner
//   cmp_valid          out  [NUM_REQ]      one-cycle completion pulse to the owner
//   cmp_error          out  1              qualifies cmp_valid: 1 = watchdog abort
//   core_start         out  1              start pulse to the core
//   core_message_addr  out  16             message address of the current job
//   core_output_addr   out  16             output address of the current job
//   core_done          in   1              core level-done, high while core is idle
//   core_reset_n       out  1              active-low reset to the core
//   busy               out  1              high in every state except IDLE
//   grant_id           out  GW             current or most recent grant index
//
// Every output is decoded from registered state or registered data, so there
// is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module sha256_job_scheduler #(
  parameter int  NUM_REQ = 4,
  parameter int  TIMEOUT = 2048,
  localparam int GW      = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*16-1:0]  req_msg_addr,
  input  logic [NUM_REQ*16-1:0]  req_out_addr,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     cmp_valid,
  output logic                   cmp_error,
  output logic                   core_start,
  output logic [15:0]            core_message_addr,
  output logic [15:0]            core_output_addr,
  input  logic                   core_done,
  output logic                   core_reset_n,
  output logic                   busy,
  output logic [GW-1:0]          grant_id
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_COMPLETE,
    S_RECOVER1,
    S_RECOVER2
  } state_e;

  // Last watchdog count before abort; TIMEOUT is at most 65535 so it fits.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [GW-1:0]   grant_id_q, grant_id_d;
  logic [15:0]     msg_addr_q, msg_addr_d;
  logic [15:0]     out_addr_q, out_addr_d;
  logic [15:0]     wd_cnt_q, wd_cnt_d;
  // Low during reset and for the first cycle after it; releases the core
  // one edge after the scheduler itself leaves reset.
  logic            core_rel_q, core_rel_d;

  // -------------------------------------------------------------------------
  // Unpack the per-requester address buses.
  // -------------------------------------------------------------------------
  logic [15:0] msg_arr [NUM_REQ];
  logic [15:0] out_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign msg_arr[i] = req_msg_addr[16*i +: 16];
    assign out_arr[i] = req_out_addr[16*i +: 16];
  end

  // -------------------------------------------------------------------------
  // Round-robin arbiter: first set request searching upward from
  // last_grant+1, wrapping modulo NUM_REQ.
  // -------------------------------------------------------------------------
  logic          arb_found;
  logic [GW-1:0] arb_winner;
  logic [GW-1:0] arb_idx;

  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise a path that skips the assignment infers a latch.
    arb_found  = 1'b0;
    arb_winner = '0;
    arb_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      arb_idx = GW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!arb_found && req_valid[arb_idx]) begin
        arb_found  = 1'b1;
        arb_winner = arb_idx;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    msg_addr_d   = msg_addr_q;
    out_addr_d   = out_addr_q;
    wd_cnt_d     = wd_cnt_q;
    core_rel_d   = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        // A low core_done here means the core is still held or recovering.
        if (arb_found && core_done) begin
          grant_id_d   = arb_winner;
          last_grant_d = arb_winner;
          msg_addr_d   = msg_arr[arb_winner];
          out_addr_d   = out_arr[arb_winner];
          state_d      = S_START;
        end
      end

      S_START: begin
        wd_cnt_d = '0;
        state_d  = S_WAIT_BUSY;
      end

      // The watchdog keeps counting across the WAIT_BUSY -> WAIT_DONE hop so
      // the limit is measured from the start pulse. A done edge seen in the
      // same cycle as the last count takes priority over the abort.
      S_WAIT_BUSY: begin
        wd_cnt_d = wd_cnt_q + 16'd1;
        if (!core_done) begin
          state_d = S_WAIT_DONE;
        end else if (wd_cnt_q == WD_LAST) begin
          state_d = S_RECOVER1;
        end
      end

      S_WAIT_DONE: begin
        wd_cnt_d = wd_cnt_q + 16'd1;
        if (core_done) begin
          state_d = S_COMPLETE;
        end else if (wd_cnt_q == WD_LAST) begin
          state_d = S_RECOVER1;
        end
      end

      S_COMPLETE: state_d = S_IDLE;
      S_RECOVER1: state_d = S_RECOVER2;
      S_RECOVER2: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and data registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_id_q   <= '0;
      msg_addr_q   <= '0;
      out_addr_q   <= '0;
      wd_cnt_q     <= '0;
      core_rel_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      msg_addr_q   <= msg_addr_d;
      out_addr_q   <= out_addr_d;
      wd_cnt_q     <= wd_cnt_d;
      core_rel_q   <= core_rel_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode, purely from registered state and data
  // -------------------------------------------------------------------------
  logic [NUM_REQ-1:0] grant_onehot;
  logic               in_recover;

  assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_q;
  assign in_recover   = (state_q == S_RECOVER1) || (state_q == S_RECOVER2);

  always_comb begin
    req_ready    = '0;
    cmp_valid    = '0;
    cmp_error    = 1'b0;
    core_start   = 1'b0;
    unique case (state_q)
      S_START: begin
        req_ready  = grant_onehot;
        core_start = 1'b1;
      end
      S_COMPLETE: begin
        cmp_valid = grant_onehot;
      end
      S_RECOVER2: begin
        cmp_valid = grant_onehot;
        cmp_error = 1'b1;
      end
      default: ;
    endcase
  end

  assign core_reset_n      = core_rel_q && !in_recover;
  assign busy              = (state_q != S_IDLE);
  assign grant_id          = grant_id_q;
  assign core_message_addr = msg_addr_q;
  assign core_output_addr  = out_addr_q;

endmodule
